// File: rtl/puzzle_loader_pkg.sv
// rtl/puzzle_loader_pkg.sv - shared sudoku board constants and loader state encoding
// Purpose: board geometry, cell value width, empty cell code and the
//          loader FSM state type used by puzzle_loader and symbol_decoder.
// Ports:   none (package).
package puzzle_loader_pkg;

  localparam int NUM_CELLS = 81;
  localparam int CELL_W    = 4;

  localparam logic [CELL_W-1:0] EMPTY_CELL = 4'd0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_FINISH = 2'd2,
    S_ERROR  = 2'd3
  } loader_state_t;

endpackage

// File: rtl/symbol_decoder.sv
// rtl/symbol_decoder.sv - combinational upstream symbol to cell value decoder
// Purpose: maps one 8-bit upstream symbol to a 4-bit cell value and a legal
//          flag. Illegal symbols return value 0 with legal low.
//          Build option LOADER_ASCII_EN: accept ASCII '0'..'9' and '.';
//          otherwise accept raw bytes 0x00..0x09.
// Ports:   sym   - upstream symbol
//          value - decoded cell value, 0 = empty
//          legal - symbol is part of the accepted alphabet
module symbol_decoder
  import puzzle_loader_pkg::*;
(
  input  logic [7:0]        sym,
  output logic [CELL_W-1:0] value,
  output logic              legal
);

  always_comb begin
    value = EMPTY_CELL;
    legal = 1'b0;
`ifdef LOADER_ASCII_EN
    if (sym >= 8'h31 && sym <= 8'h39) begin
      // '1'..'9' carry their value in the low nibble
      value = sym[3:0];
      legal = 1'b1;
    end else if (sym == 8'h30 || sym == 8'h2E) begin
      // '0' and '.' both mean an empty cell
      value = EMPTY_CELL;
      legal = 1'b1;
    end
`else
    if (sym <= 8'h09) begin
      value = sym[3:0];
      legal = 1'b1;
    end
`endif
  end

endmodule

// File: rtl/puzzle_loader.sv
// rtl/puzzle_loader.sv - streams one sudoku frame into board memory and kicks the solver
// Purpose: accepts NUM_CELLS symbols after load_req, writes each decoded cell
//          to board memory one cycle after acceptance, then pulses
//          start_solver. A bad symbol parks the loader in ERROR.
//          Symbol alphabet selected by LOADER_ASCII_EN (see symbol_decoder).
// Ports:   clk, rst          - clock, synchronous active-high reset
//          load_req          - begin (or restart) a frame
//          in_valid, in_data - upstream symbol stream; in_ready handshake
//          cell_index, data_in_mem, write_en - board memory write port
//          start_solver      - one-cycle solver start pulse
//          busy              - high in LOAD and FINISH
//          load_done, load_error - sticky frame status
//          given_count       - nonzero cells in the last frame
module puzzle_loader #(
  parameter int NUM_CELLS = puzzle_loader_pkg::NUM_CELLS,
  parameter int IDX_W     = 7
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                load_req,
  input  logic                                in_valid,
  input  logic [7:0]                          in_data,
  output logic                                in_ready,
  output logic [IDX_W-1:0]                    cell_index,
  output logic [puzzle_loader_pkg::CELL_W-1:0] data_in_mem,
  output logic                                write_en,
  output logic                                start_solver,
  output logic                                busy,
  output logic                                load_done,
  output logic                                load_error,
  output logic [6:0]                          given_count
);

  import puzzle_loader_pkg::*;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CELLS - 1);

  loader_state_t     state_q, state_d;
  logic [IDX_W-1:0]  next_idx_q, next_idx_d;
  logic [6:0]        given_q, given_d;
  logic              write_en_q, write_en_d;
  logic [IDX_W-1:0]  cell_index_q, cell_index_d;
  logic [CELL_W-1:0] data_q, data_d;
  logic              start_q, start_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [CELL_W-1:0] dec_value;
  logic              dec_legal;
  logic              accept;

  symbol_decoder u_decoder (
    .sym   (in_data),
    .value (dec_value),
    .legal (dec_legal)
  );

  // A restart request wins over a beat in the same cycle, so ready is
  // withheld while load_req is high.
  assign in_ready = (state_q == S_LOAD) && !load_req;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d      = state_q;
    next_idx_d   = next_idx_q;
    given_d      = given_q;
    write_en_d   = 1'b0;
    cell_index_d = cell_index_q;
    data_d       = data_q;
    start_d      = 1'b0;
    done_d       = done_q;
    err_d        = err_q;

    case (state_q)
      S_IDLE, S_ERROR: begin
        if (load_req) begin
          state_d    = S_LOAD;
          next_idx_d = '0;
          given_d    = 7'd0;
          done_d     = 1'b0;
          err_d      = 1'b0;
        end
      end
      S_LOAD: begin
        if (load_req) begin
          next_idx_d = '0;
          given_d    = 7'd0;
          done_d     = 1'b0;
          err_d      = 1'b0;
        end else if (accept) begin
          if (dec_legal) begin
            write_en_d   = 1'b1;
            cell_index_d = next_idx_q;
            data_d       = dec_value;
            next_idx_d   = next_idx_q + 1'b1;
            if (dec_value != EMPTY_CELL) begin
              given_d = given_q + 7'd1;
            end
            if (next_idx_q == LAST_IDX) begin
              state_d = S_FINISH;
            end
          end else begin
            state_d = S_ERROR;
            err_d   = 1'b1;
          end
        end
      end
      S_FINISH: begin
        // FINISH coincides with the last write; the registered start pulse
        // therefore lands one cycle after it.
        start_d = 1'b1;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      next_idx_q   <= '0;
      given_q      <= 7'd0;
      write_en_q   <= 1'b0;
      cell_index_q <= '0;
      data_q       <= EMPTY_CELL;
      start_q      <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      next_idx_q   <= next_idx_d;
      given_q      <= given_d;
      write_en_q   <= write_en_d;
      cell_index_q <= cell_index_d;
      data_q       <= data_d;
      start_q      <= start_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign cell_index   = cell_index_q;
  assign data_in_mem  = data_q;
  assign write_en     = write_en_q;
  assign start_solver = start_q;
  assign busy         = (state_q == S_LOAD) || (state_q == S_FINISH);
  assign load_done    = done_q;
  assign load_error   = err_q;
  assign given_count  = given_q;

endmodule

// File: tb/tb_puzzle_loader.sv
// tb/tb_puzzle_loader.sv - directed self-checking bench for puzzle_loader
module tb_puzzle_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_req;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [6:0] cell_index;
  logic [3:0] data_in_mem;
  logic       write_en;
  logic       start_solver;
  logic       busy;
  logic       load_done;
  logic       load_error;
  logic [6:0] given_count;

  int errors = 0;
  int checks = 0;

  // Standard test puzzle, row-major, 0 = empty, 30 givens.
  string puzzle = "530070000600195000098000060800060003400803001700020006060000280000419005000080079";

  puzzle_loader #(.NUM_CELLS(81), .IDX_W(7)) dut (
    .clk          (clk),
    .rst          (rst),
    .load_req     (load_req),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .cell_index   (cell_index),
    .data_in_mem  (data_in_mem),
    .write_en     (write_en),
    .start_solver (start_solver),
    .busy         (busy),
    .load_done    (load_done),
    .load_error   (load_error),
    .given_count  (given_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] dig(input int i);
    byte c;
    c = puzzle[i];
    return 4'(c - 8'h30);
  endfunction

  function automatic logic [7:0] enc(input logic [3:0] v);
`ifdef LOADER_ASCII_EN
    return 8'h30 + {4'h0, v};
`else
    return {4'h0, v};
`endif
  endfunction

  function automatic logic [7:0] bad_sym();
`ifdef LOADER_ASCII_EN
    return 8'h41;
`else
    return 8'h0C;
`endif
  endfunction

  task automatic test_reset();
    rst = 1'b1; load_req = 1'b1; in_valid = 1'b1; in_data = 8'h05;
    tick(); tick();
    checks++;
    if ({in_ready, cell_index, data_in_mem, write_en, start_solver, busy,
         load_done, load_error, given_count} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b idx=%0d dat=%0d we=%b st=%b busy=%b done=%b err=%b gc=%0d, want all 0",
               in_ready, cell_index, data_in_mem, write_en, start_solver, busy, load_done, load_error, given_count);
    end
    rst = 1'b0; load_req = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    tick();
    checks++;
    if (busy !== 1'b0 || write_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b we=%b, want 0 0", busy, write_en);
    end
  endtask

  task automatic test_full_frame();
    load_req = 1'b1; tick(); load_req = 1'b0;
    checks++;
    if (busy !== 1'b1 || load_done !== 1'b0) begin
      errors++;
      $display("FAIL full_start: busy=%b done=%b, want 1 0", busy, load_done);
    end
    for (int i = 0; i < 81; i++) begin
      in_valid = 1'b1; in_data = enc(dig(i));
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL full_ready beat %0d: in_ready=%b, want 1", i, in_ready);
      end
      tick();
      checks++;
      if (write_en !== 1'b1 || cell_index !== 7'(i) || data_in_mem !== dig(i) || start_solver !== 1'b0) begin
        errors++;
        $display("FAIL full_write beat %0d: we=%b idx=%0d dat=%0d st=%b, want 1 %0d %0d 0",
                 i, write_en, cell_index, data_in_mem, start_solver, i, dig(i));
      end
    end
    // still holding in_valid: FINISH must not accept anything
    in_data = enc(4'd7);
    #1;
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL full_finish: in_ready=%b busy=%b, want 0 1", in_ready, busy);
    end
    tick();
    checks++;
    if (start_solver !== 1'b1 || write_en !== 1'b0 || load_done !== 1'b1 ||
        given_count !== 7'd30 || busy !== 1'b0) begin
      errors++;
      $display("FAIL full_start_pulse: st=%b we=%b done=%b gc=%0d busy=%b, want 1 0 1 30 0",
               start_solver, write_en, load_done, given_count, busy);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (start_solver !== 1'b0 || write_en !== 1'b0 || load_done !== 1'b1) begin
        errors++;
        $display("FAIL full_after %0d: st=%b we=%b done=%b, want 0 0 1", k, start_solver, write_en, load_done);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_toggle();
    int k;
    int starts;
    k = 0;
    starts = 0;
    load_req = 1'b1; tick(); load_req = 1'b0;
    for (int c = 0; c < 200 && k < 81; c++) begin
      in_valid = (c % 2 == 0);
      in_data  = enc(dig(k));
      tick();
      checks++;
      if (c % 2 == 0) begin
        if (write_en !== 1'b1 || cell_index !== 7'(k) || data_in_mem !== dig(k)) begin
          errors++;
          $display("FAIL toggle_write k=%0d: we=%b idx=%0d dat=%0d, want 1 %0d %0d",
                   k, write_en, cell_index, data_in_mem, k, dig(k));
        end
        k++;
      end else if (write_en !== 1'b0) begin
        errors++;
        $display("FAIL toggle_idle c=%0d: we=%b, want 0", c, write_en);
      end
    end
    checks++;
    if (k !== 81) begin
      errors++;
      $display("FAIL toggle_count: beats=%0d, want 81", k);
    end
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (start_solver === 1'b1) starts++;
    end
    checks++;
    if (starts !== 1 || given_count !== 7'd30 || load_done !== 1'b1) begin
      errors++;
      $display("FAIL toggle_end: starts=%0d gc=%0d done=%b, want 1 30 1", starts, given_count, load_done);
    end
  endtask

  task automatic test_error();
    load_req = 1'b1; tick(); load_req = 1'b0;
    checks++;
    if (load_done !== 1'b0) begin
      errors++;
      $display("FAIL error_done_clear: done=%b, want 0", load_done);
    end
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = enc(dig(i));
      tick();
    end
    checks++;
    if (write_en !== 1'b1 || cell_index !== 7'd9) begin
      errors++;
      $display("FAIL error_pre: we=%b idx=%0d, want 1 9", write_en, cell_index);
    end
    in_data = bad_sym();
    tick();
    checks++;
    if (write_en !== 1'b0 || load_error !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL error_flag: we=%b err=%b rdy=%b busy=%b, want 0 1 0 0",
               write_en, load_error, in_ready, busy);
    end
    in_data = enc(4'd3);
    for (int c = 0; c < 100; c++) begin
      tick();
      checks++;
      if (write_en !== 1'b0 || start_solver !== 1'b0 || load_error !== 1'b1) begin
        errors++;
        $display("FAIL error_hold c=%0d: we=%b st=%b err=%b, want 0 0 1", c, write_en, start_solver, load_error);
      end
    end
    in_valid = 1'b0;
    load_req = 1'b1; tick(); load_req = 1'b0;
    checks++;
    if (load_error !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL error_clear: err=%b busy=%b, want 0 1", load_error, busy);
    end
  endtask

  task automatic test_abort();
    int starts;
    starts = 0;
    load_req = 1'b1; tick(); load_req = 1'b0;
    for (int i = 0; i < 40; i++) begin
      in_valid = 1'b1; in_data = enc(dig(i));
      tick();
    end
    // beat 40 coincides with a restart and must be dropped
    load_req = 1'b1; in_valid = 1'b1; in_data = enc(4'd9);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort_ready: in_ready=%b, want 0", in_ready);
    end
    tick();
    load_req = 1'b0;
    checks++;
    if (write_en !== 1'b0 || given_count !== 7'd0) begin
      errors++;
      $display("FAIL abort_nowrite: we=%b gc=%0d, want 0 0", write_en, given_count);
    end
    for (int i = 0; i < 81; i++) begin
      in_data = enc(dig(i));
      tick();
      checks++;
      if (write_en !== 1'b1 || cell_index !== 7'(i) || data_in_mem !== dig(i)) begin
        errors++;
        $display("FAIL abort_write beat %0d: we=%b idx=%0d dat=%0d, want 1 %0d %0d",
                 i, write_en, cell_index, data_in_mem, i, dig(i));
      end
    end
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (start_solver === 1'b1) starts++;
    end
    checks++;
    if (starts !== 1 || given_count !== 7'd30 || load_done !== 1'b1) begin
      errors++;
      $display("FAIL abort_end: starts=%0d gc=%0d done=%b, want 1 30 1", starts, given_count, load_done);
    end
    // load_req in FINISH is ignored: no second start, no restart
  endtask

  task automatic test_finish_ignore();
    load_req = 1'b1; tick(); load_req = 1'b0;
    for (int i = 0; i < 81; i++) begin
      in_valid = 1'b1; in_data = enc(dig(i));
      tick();
    end
    in_valid = 1'b0;
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    checks++;
    if (start_solver !== 1'b1 || load_done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL finish_ignore: st=%b done=%b busy=%b, want 1 1 0", start_solver, load_done, busy);
    end
  endtask

  task automatic test_reset_mid();
    load_req = 1'b1; tick(); load_req = 1'b0;
    for (int i = 0; i < 50; i++) begin
      in_valid = 1'b1; in_data = enc(dig(i));
      tick();
    end
    rst = 1'b1; in_data = enc(4'd4);
    tick();
    checks++;
    if ({in_ready, cell_index, data_in_mem, write_en, start_solver, busy,
         load_done, load_error, given_count} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: rdy=%b idx=%0d dat=%0d we=%b st=%b busy=%b done=%b err=%b gc=%0d, want all 0",
               in_ready, cell_index, data_in_mem, write_en, start_solver, busy, load_done, load_error, given_count);
    end
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (write_en !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL midreset_quiet c=%0d: we=%b rdy=%b busy=%b, want 0 0 0", c, write_en, in_ready, busy);
      end
    end
    in_valid = 1'b0;
  endtask

`ifdef LOADER_ASCII_EN
  task automatic test_ascii();
    string s;
    logic [3:0] exp_v;
    s = "53..7....";
    load_req = 1'b1; tick(); load_req = 1'b0;
    for (int i = 0; i < 81; i++) begin
      in_valid = 1'b1;
      in_data  = (i < 9) ? 8'(s[i]) : 8'h2E;
      exp_v    = (i == 0) ? 4'd5 : (i == 1) ? 4'd3 : (i == 4) ? 4'd7 : 4'd0;
      tick();
      checks++;
      if (write_en !== 1'b1 || cell_index !== 7'(i) || data_in_mem !== exp_v) begin
        errors++;
        $display("FAIL ascii_write beat %0d: we=%b idx=%0d dat=%0d, want 1 %0d %0d",
                 i, write_en, cell_index, data_in_mem, i, exp_v);
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (start_solver !== 1'b1 || given_count !== 7'd3) begin
      errors++;
      $display("FAIL ascii_end: st=%b gc=%0d, want 1 3", start_solver, given_count);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; load_req = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    test_reset();
    test_full_frame();
    test_toggle();
    test_error();
    test_abort();
    test_finish_ignore();
    test_reset_mid();
`ifdef LOADER_ASCII_EN
    test_ascii();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/puzzle_loader.md
PUZZLE_LOADER -- requirements
Module: puzzle_loader

Interface
- REQ-001 Parameter NUM_CELLS, default 81, number of board cells written per frame.
- REQ-002 Parameter IDX_W, default 7, width of cell_index.
- REQ-003 clk  input  1  single clock; all logic on its rising edge.
- REQ-004 rst  input  1  synchronous, active-high reset.
- REQ-005 load_req  input  1  one-cycle request to begin loading a new frame.
- REQ-006 in_valid  input  1  upstream symbol valid.
- REQ-007 in_data  input  8  upstream symbol.
- REQ-008 in_ready  output  1  loader accepts a symbol this cycle.
- REQ-009 cell_index  output  IDX_W  board_memory write address.
- REQ-010 data_in_mem  output  4  board_memory write data, 0 = empty, 1..9 = given.
- REQ-011 write_en  output  1  board_memory write strobe.
- REQ-012 start_solver  output  1  one-cycle pulse to sudoku_controller start.
- REQ-013 busy  output  1  high in LOAD and FINISH.
- REQ-014 load_done  output  1  sticky success flag.
- REQ-015 load_error  output  1  sticky bad-symbol flag.
- REQ-016 given_count  output  7  number of nonzero cells in the last frame.

Function
- REQ-017 States SHALL be IDLE, LOAD, FINISH and ERROR.
- REQ-018 IDLE -> LOAD on load_req: next_idx SHALL be 0, given_count SHALL be 0, and load_done and load_error SHALL be cleared.
- REQ-019 in_ready SHALL be high only in LOAD; a beat SHALL be accepted when in_valid && in_ready.
- REQ-020 Each accepted legal beat SHALL produce write_en=1 on the next cycle, with cell_index=next_idx and data_in_mem=the decoded value; each beat writes exactly one cell.
- REQ-021 write_en SHALL be low on every cycle that does not follow an accepted legal beat; back-to-back beats SHALL give one write per cycle.
- REQ-022 next_idx SHALL increment by 1 per accepted legal beat; given_count SHALL increment when the decoded value is nonzero.
- REQ-023 Acceptance of beat NUM_CELLS-1 SHALL move the state to FINISH and drop in_ready the following cycle; no index beyond NUM_CELLS-1 is ever written.
- REQ-024 In FINISH, start_solver SHALL be high for exactly one cycle, issued the cycle after the final write_en. load_done SHALL then be set and the state SHALL return to IDLE.
- REQ-025 An accepted illegal symbol SHALL cause no write. The state SHALL go to ERROR and load_error SHALL be set. start_solver SHALL never fire for that frame.
- REQ-026 ERROR SHALL hold until load_req, which behaves as in IDLE.
- REQ-027 load_req in LOAD SHALL abort the frame and restart it at index 0 with counters cleared; a beat presented in that same cycle SHALL NOT be accepted.
- REQ-028 load_req in FINISH SHALL be ignored.
- REQ-029 in_valid outside LOAD SHALL be ignored.

Reset
- REQ-030 On rst the state SHALL be IDLE and every output SHALL be 0, including cell_index, next_idx and given_count.
- REQ-031 rst SHALL take priority over load_req and beats; rst mid-LOAD SHALL discard the frame with no further writes.

Configuration
- REQ-032 With LOADER_ASCII_EN defined, the legal symbols SHALL be '1'..'9' (0x31..0x39), mapped to 1..9, plus '0' (0x30) and '.' (0x2E), both mapped to 0; all other symbols SHALL be illegal.
- REQ-033 Without LOADER_ASCII_EN, the legal symbols SHALL be 0x00..0x09, with data_in_mem=in_data[3:0]; all other symbols SHALL be illegal.

Structure
- REQ-034 A shared sudoku package SHALL hold NUM_CELLS, the cell-value width (4), the empty code (0) and the loader state encoding.
- REQ-035 Symbol decode SHALL be one sub-module, symbol_decoder: combinational, with outputs value[3:0] and legal, and the only logic affected by LOADER_ASCII_EN.

Verification
- REQ-036 Raw mode, load_req then 81 beats with in_valid held high: 81 consecutive write_en, indices 0..80, then start_solver one cycle after index 80, load_done=1, given_count matching the puzzle (30 for the standard test puzzle).
- REQ-037 in_valid toggled every other cycle: writes only on cycles following accepted beats, with indices contiguous.
- REQ-038 Beat 10 = 0x0C (raw) or 'A' (ASCII): no write for cell 10, load_error=1, in_ready=0, start_solver never high; a following load_req clears load_error.
- REQ-039 load_req at beat 40: the next write is index 0, and a full frame then completes with given_count counted for the new frame only.
- REQ-040 rst asserted at beat 50: all outputs 0 the next cycle and no write_en until a new load_req.
- REQ-041 ASCII mode, the symbols "53..7...." followed by 72 '.': cells 0=5, 1=3, 4=7, the rest 0, given_count=3.
